phase_accumulator_sweep: RTL and testbench
==========================================

Name: phase_accumulator_sweep

Overview:
Parametrised DDFS phase accumulator, successor to the fixed 8-bit accumulator. N-bit frequency tuning word (FTW) with run-time load, a phase offset added after truncation, and a linear frequency-sweep (chirp) mode. Output `q` drives the phase-to-amplitude LUT. `wrap` marks each accumulator overflow for downstream cycle counting and synchronisation.

Parameters:
- ACC_WIDTH, 16, accumulator and FTW width in bits (>= OUT_WIDTH, <= 48).
- OUT_WIDTH, 8, truncated phase output width (LUT address width).
- FTW_RESET, 1, FTW value loaded at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  accumulate-enable; when low, accumulator and sweep hold.
- sync_clear  in  1  one-cycle pulse; zeroes accumulator, FTW kept.
- ftw_in  in  ACC_WIDTH  new tuning word / sweep start value.
- ftw_load  in  1  one-cycle pulse; captures ftw_in.
- sweep_en  in  1  level; selects sweep mode when ftw_load occurs.
- sweep_step  in  ACC_WIDTH  unsigned FTW increment per enabled cycle in sweep.
- ftw_limit  in  ACC_WIDTH  sweep end FTW (unsigned).
- phase_offset  in  OUT_WIDTH  phase offset added to truncated phase.
- q  out  OUT_WIDTH  registered output phase.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- ftw_active  out  ACC_WIDTH  FTW currently in use.
- sweep_done  out  1  high while in state DONE.

Behaviour:
- Reset (sync, reset=1 at edge):
  - acc=0, ftw_active=FTW_RESET, q=0, wrap=0, sweep_done=0, state=FIXED.
- Accumulation on enabled cycle: `{carry, acc} <= acc + ftw_active` (ACC_WIDTH+1-bit sum, modulo 2^ACC_WIDTH). `wrap <= carry`. `wrap=0` on any non-enabled cycle.
- q, updated every cycle regardless of enable: `q <= acc[ACC_WIDTH-1 -: OUT_WIDTH] + phase_offset` (mod 2^OUT_WIDTH), using the registered acc. Latency: acc change appears on q one cycle later; phase_offset change appears on q next edge.
- FSM states:
  - FIXED: ftw_active constant.
  - SWEEP: on each enabled cycle, `ftw_active <= min(ftw_active + sweep_step, ftw_limit)`; sum computed at ACC_WIDTH+1 bits so overflow saturates to ftw_limit. When the new value equals ftw_limit -> DONE.
  - DONE: ftw_active held at ftw_limit; sweep_done=1.
- Transitions on ftw_load:
  - `ftw_active <= ftw_in`.
  - If sweep_en=1 and ftw_in < ftw_limit -> SWEEP.
  - If sweep_en=1 and ftw_in >= ftw_limit -> DONE with ftw_active=ftw_in (no sweep).
  - If sweep_en=0 -> FIXED.
  - ftw_load is accepted from any state, including mid-sweep; the accumulator is not disturbed (phase-continuous).
- Priority in one cycle: reset > sync_clear > ftw_load > accumulate/sweep step.
  - sync_clear: `acc <= 0`, `wrap <= 0`; the accumulate is skipped that cycle; ftw_active/state unchanged unless ftw_load also high (both take effect).
  - ftw_load with enable=1: the accumulate in that cycle uses the old ftw_active; the new FTW applies from the next cycle. No sweep step in the load cycle.
- sweep_step=0 in SWEEP: ftw_active is held; stays in SWEEP.
- enable low: acc, ftw_active and state hold; q still tracks phase_offset.

Optional Feature:
- Macro: PHASE_ACC_DITHER_EN.
- Defined: 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 0xACE1 at reset), advanced on enabled cycles. Its low (ACC_WIDTH-OUT_WIDTH) bits, capped at 16 bits, are added to acc before truncation for q only. The dither does not feed back into acc or wrap. This suppresses truncation spurs.
- Undefined: no LFSR; q is exactly as specified above.

Test Plan:
- Reset: hold reset 5 cycles with enable=1 -> q=0, wrap=0, ftw_active=0x0001, sweep_done=0.
- Fixed FTW: load ftw_in=0x0100, enable=1, offset=0 -> q steps 0,1,2…,0xFF,0x00; wrap pulses once every 256 cycles, one cycle wide.
- Offset: same as previous case, then set phase_offset=0x40 mid-run -> q jumps by +0x40 on the next edge (mod 256); wrap timing unchanged.
- Sweep: ftw_in=0x0100, sweep_step=0x0100, ftw_limit=0x0400, sweep_en=1 -> ftw_active 0x0100, 0x0200, 0x0300, 0x0400 on successive enabled cycles; sweep_done=1 from the cycle it reaches 0x0400 and holds.
- Saturation: ftw_in=0xFF00, sweep_step=0x0200, ftw_limit=0xFFFF -> next value 0xFFFF (no wrap to 0x0100); DONE.
- Simultaneous events: sync_clear and ftw_load(0x0200) in the same cycle with enable=1 -> acc=0, ftw_active=0x0200, no wrap; next cycle acc=0x0200. Then enable=0 for 10 cycles -> acc and q hold.

Source files
------------

// File: rtl/phase_accumulator_sweep.sv
// DDFS phase accumulator with run-time FTW load, post-truncation phase offset and linear chirp.
// Optional LFSR truncation dither on q is enabled by defining PHASE_ACC_DITHER_EN.
module phase_accumulator_sweep #(
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter logic [ACC_WIDTH-1:0] FTW_RESET = {{(ACC_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sync_clear,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_load,
    input  logic                 sweep_en,
    input  logic [ACC_WIDTH-1:0] sweep_step,
    input  logic [ACC_WIDTH-1:0] ftw_limit,
    input  logic [OUT_WIDTH-1:0] phase_offset,
    output logic [OUT_WIDTH-1:0] q,
    output logic                 wrap,
    output logic [ACC_WIDTH-1:0] ftw_active,
    output logic                 sweep_done
);

    typedef enum logic [1:0] {
        ST_FIXED = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   ftw_q, ftw_d;
    logic [OUT_WIDTH-1:0]   phase_q, phase_d;
    logic                   wrap_q, wrap_d;
    logic                   done_q, done_d;

    logic [ACC_WIDTH:0]     acc_sum_s;
    logic [ACC_WIDTH:0]     step_sum_s;
    logic [ACC_WIDTH-1:0]   stepped_s;
    logic [ACC_WIDTH-1:0]   dither_s;
    logic [ACC_WIDTH-1:0]   dithered_s;

`ifdef PHASE_ACC_DITHER_EN
    localparam int DW = ((ACC_WIDTH - OUT_WIDTH) > 16) ? 16 : (ACC_WIDTH - OUT_WIDTH);
    localparam logic [15:0] DMASK = 16'((17'd1 << DW) - 17'd1);

    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR x^16+x^14+x^13+x^11+1, stepped only on enabled cycles
    always_comb begin
        if (enable) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither_s = ACC_WIDTH'(lfsr_q & DMASK);
`else
    assign dither_s = {ACC_WIDTH{1'b0}};
`endif

    assign acc_sum_s  = {1'b0, acc_q} + {1'b0, ftw_q};
    assign step_sum_s = {1'b0, ftw_q} + {1'b0, sweep_step};
    // Saturating chirp step: the extra sum bit keeps an overflow from wrapping past the limit
    assign stepped_s  = (step_sum_s >= {1'b0, ftw_limit}) ? ftw_limit : step_sum_s[ACC_WIDTH-1:0];
    assign dithered_s = acc_q + dither_s;

    // Next-state logic: sync_clear > ftw_load > accumulate / sweep step
    always_comb begin
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        state_d = state_q;
        wrap_d  = 1'b0;

        if (sync_clear) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (enable) begin
            acc_d  = acc_sum_s[ACC_WIDTH-1:0];
            wrap_d = acc_sum_s[ACC_WIDTH];
        end else begin
            acc_d = acc_q;
        end

        if (ftw_load) begin
            ftw_d = ftw_in;
            if (!sweep_en) begin
                state_d = ST_FIXED;
            end else if (ftw_in < ftw_limit) begin
                state_d = ST_SWEEP;
            end else begin
                state_d = ST_DONE;
            end
        end else if (enable && !sync_clear) begin
            case (state_q)
                ST_SWEEP: begin
                    ftw_d = stepped_s;
                    if (stepped_s == ftw_limit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SWEEP;
                    end
                end
                ST_FIXED: state_d = ST_FIXED;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_FIXED;
            endcase
        end else begin
            state_d = state_q;
        end

        done_d  = (state_d == ST_DONE);
        phase_d = dithered_s[ACC_WIDTH-1 -: OUT_WIDTH] + phase_offset;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FIXED;
            acc_q   <= {ACC_WIDTH{1'b0}};
            ftw_q   <= FTW_RESET;
            phase_q <= {OUT_WIDTH{1'b0}};
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign q          = phase_q;
    assign wrap       = wrap_q;
    assign ftw_active = ftw_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_phase_accumulator_sweep.sv
// Randomised and directed bench for phase_accumulator_sweep against an arithmetic reference model.
module tb_phase_accumulator_sweep;

    logic        clk = 1'b0;
    logic        reset, enable, sync_clear, ftw_load, sweep_en;
    logic [15:0] ftw_in, sweep_step, ftw_limit;
    logic [7:0]  phase_offset;
    logic [7:0]  q;
    logic        wrap, sweep_done;
    logic [15:0] ftw_active;

    int total = 0;
    int bad   = 0;

    // reference model: plain integer arithmetic
    longint m_acc, m_ftw;
    longint m_q;
    bit     m_wrap, m_sweeping, m_done;

    phase_accumulator_sweep dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
        .ftw_in(ftw_in), .ftw_load(ftw_load), .sweep_en(sweep_en),
        .sweep_step(sweep_step), .ftw_limit(ftw_limit), .phase_offset(phase_offset),
        .q(q), .wrap(wrap), .ftw_active(ftw_active), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        longint s;
        longint nq;
        nq = ((m_acc >> 8) + longint'(phase_offset)) % 256;
        if (reset) begin
            m_acc = 0; m_ftw = 1; m_q = 0; m_wrap = 0; m_sweeping = 0; m_done = 0;
        end else begin
            m_q = nq;
            m_wrap = 0;
            if (sync_clear) begin
                m_acc = 0;
            end else if (enable) begin
                s = m_acc + m_ftw;
                m_wrap = (s >= 65536);
                m_acc = s % 65536;
            end
            if (ftw_load) begin
                m_ftw = ftw_in;
                m_sweeping = sweep_en && (longint'(ftw_in) < longint'(ftw_limit));
                m_done     = sweep_en && (longint'(ftw_in) >= longint'(ftw_limit));
            end else if (enable && !sync_clear && m_sweeping) begin
                s = m_ftw + longint'(sweep_step);
                if (s >= longint'(ftw_limit)) s = ftw_limit;
                m_ftw = s;
                if (s == longint'(ftw_limit)) begin
                    m_sweeping = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("q", q, m_q);
        check("wrap", wrap, m_wrap);
        check("ftw_active", ftw_active, m_ftw);
        check("sweep_done", sweep_done, m_done);
    endtask

    initial begin
        int     wraps;
        logic [7:0] q_hold;
        reset = 1'b1; enable = 1'b1; sync_clear = 1'b0; ftw_load = 1'b0; sweep_en = 1'b0;
        ftw_in = 16'h0000; sweep_step = 16'h0000; ftw_limit = 16'h0000; phase_offset = 8'h00;
        m_acc = 0; m_ftw = 1; m_q = 0; m_wrap = 0; m_sweeping = 0; m_done = 0;

        // reset
        repeat (5) step();
        check("rst_q", q, 64'h0);
        check("rst_wrap", wrap, 64'h0);
        check("rst_ftw", ftw_active, 64'h1);
        check("rst_done", sweep_done, 64'h0);
        reset = 1'b0;

        // fixed FTW
        ftw_in = 16'h0100; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        wraps = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            wraps += int'(wrap);
        end
        check("fixed_wraps", wraps, 64'd2);

        // phase offset mid-run
        phase_offset = 8'h40;
        repeat (20) step();
        phase_offset = 8'h00;
        step();

        // linear sweep
        ftw_in = 16'h0100; sweep_step = 16'h0100; ftw_limit = 16'h0400; sweep_en = 1'b1; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        check("sweep_start", ftw_active, 64'h0100);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("sweep_ftw", ftw_active, 64'(i * 256));
        end
        check("sweep_done_set", sweep_done, 64'h1);
        repeat (5) step();
        check("sweep_done_hold", sweep_done, 64'h1);
        check("sweep_ftw_hold", ftw_active, 64'h0400);

        // saturation
        ftw_in = 16'hFF00; sweep_step = 16'h0200; ftw_limit = 16'hFFFF; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        check("sat_start", ftw_active, 64'hFF00);
        check("sat_not_done", sweep_done, 64'h0);
        step();
        check("sat_ftw", ftw_active, 64'hFFFF);
        check("sat_done", sweep_done, 64'h1);

        // simultaneous sync_clear + ftw_load, then hold
        sweep_en = 1'b0; ftw_in = 16'h0200; ftw_load = 1'b1; sync_clear = 1'b1; enable = 1'b1;
        step();
        ftw_load = 1'b0; sync_clear = 1'b0;
        check("sim_wrap", wrap, 64'h0);
        check("sim_ftw", ftw_active, 64'h0200);
        check("sim_done", sweep_done, 64'h0);
        step();
        step();
        check("sim_q_after", q, 64'h02);
        enable = 1'b0;
        step();
        q_hold = q;
        repeat (10) step();
        check("hold_q", q, 64'(q_hold));
        enable = 1'b1;

        // random
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            sync_clear = ($urandom_range(0, 49) == 0);
            ftw_load   = ($urandom_range(0, 19) == 0);
            enable     = ($urandom_range(0, 4) != 0);
            sweep_en   = $urandom_range(0, 1) == 1;
            ftw_in     = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0800));
            if ($urandom_range(0, 7) == 0) sweep_step = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) sweep_step = 16'($urandom_range(0, 16'h0100));
            if ($urandom_range(0, 15) == 0) ftw_limit = 16'($urandom);
            if ($urandom_range(0, 9) == 0) phase_offset = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
